// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and counter mode constants.
// The conversion functions work at GRAY_MAX_W bits; callers zero-extend and keep the low WIDTH bits.
package gray_pkg;

    localparam int GRAY_MAX_W = 64;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_step_chk.sv
// Sticky monitor: after every real count step the Gray value must have changed in exactly one bit.
module gray_step_chk
    import gray_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic [WIDTH-1:0] cnt_gray,
    output logic             chk_err
);

    logic [WIDTH-1:0] prev_gray;
    logic             last_step;

    // prev_gray and last_step describe the edge that produced the current cnt_gray
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray <= '0;
            last_step <= 1'b0;
            chk_err   <= 1'b0;
        end else begin
            prev_gray <= cnt_gray;
            last_step <= step;
            if (last_step && ($countones(prev_gray ^ cnt_gray) != 1)) begin
                chk_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gray_counter_ud.sv
// Up/down Gray counter with load, wrap/saturate mode and registered flags.
// Define GRAY_CNT_CHK_EN to build the one-bit-per-step checker that drives chk_err.
module gray_counter_ud
    import gray_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int          SATURATE = MODE_WRAP,
    parameter int unsigned RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt_bin,
    output logic [WIDTH-1:0] cnt_gray,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap,
    output logic             chk_err
);

    localparam logic [WIDTH-1:0]      ALL_ONES   = '1;
    localparam logic [WIDTH-1:0]      RST_BIN    = WIDTH'(RST_VAL);
    localparam logic [GRAY_MAX_W-1:0] RST_GRAY_W = bin2gray(GRAY_MAX_W'(RST_BIN));
    localparam logic [WIDTH-1:0]      RST_GRAY   = RST_GRAY_W[WIDTH-1:0];
    localparam bit                    SAT_MODE   = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0]      bin_q;
    logic [WIDTH-1:0]      gray_q;
    logic [WIDTH-1:0]      next_bin;
    logic [GRAY_MAX_W-1:0] next_gray_w;
    logic                  next_wrap;
    logic                  count_step;
    logic                  unused_gray_hi;

    // count_step marks an enabled cycle that really moves the value (not a saturation hold)
    always_comb begin
        next_bin   = bin_q;
        next_wrap  = 1'b0;
        count_step = 1'b0;
        if (load) begin
            next_bin = load_val;
        end else if (enable) begin
            if (dir) begin
                if (bin_q == ALL_ONES) begin
                    if (!SAT_MODE) begin
                        next_bin   = '0;
                        next_wrap  = 1'b1;
                        count_step = 1'b1;
                    end
                end else begin
                    next_bin   = bin_q + 1'b1;
                    count_step = 1'b1;
                end
            end else begin
                if (bin_q == '0) begin
                    if (!SAT_MODE) begin
                        next_bin   = ALL_ONES;
                        next_wrap  = 1'b1;
                        count_step = 1'b1;
                    end
                end else begin
                    next_bin   = bin_q - 1'b1;
                    count_step = 1'b1;
                end
            end
        end
    end

    assign next_gray_w    = bin2gray(GRAY_MAX_W'(next_bin));
    assign unused_gray_hi = ^next_gray_w[GRAY_MAX_W-1:WIDTH];

    // Gray is registered from the next binary value so the output never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            at_max <= (RST_BIN == ALL_ONES);
            at_min <= (RST_BIN == '0);
            wrap   <= 1'b0;
        end else begin
            bin_q  <= next_bin;
            gray_q <= next_gray_w[WIDTH-1:0];
            at_max <= (next_bin == ALL_ONES);
            at_min <= (next_bin == '0);
            wrap   <= next_wrap;
        end
    end

    assign cnt_bin  = bin_q;
    assign cnt_gray = gray_q;

`ifdef GRAY_CNT_CHK_EN
    gray_step_chk #(
        .WIDTH(WIDTH)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .step    (count_step),
        .cnt_gray(gray_q),
        .chk_err (chk_err)
    );
`else
    logic unused_step;
    assign unused_step = count_step;
    assign chk_err     = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter_ud.sv
// Bench for gray_counter_ud: a wrapping and a saturating instance share stimulus and are checked against a behavioural model.
module tb_gray_counter_ud;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;

    logic [7:0] bin0, gray0, bin1, gray1;
    logic       amax0, amin0, wrap0, cerr0;
    logic       amax1, amin1, wrap1, cerr1;

    int total = 0;
    int bad   = 0;

    localparam int RSTV[2] = '{0, 8'hA5};
    localparam bit SATV[2] = '{1'b0, 1'b1};

    int mv[2];
    bit mw[2];
    bit mmoved[2];
    int mprev[2];
    bit mvalid   = 1'b0;
    bit pauseCmp = 1'b0;

    always #5 clk = ~clk;

    gray_counter_ud #(.WIDTH(8), .SATURATE(0), .RST_VAL(0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .dir(dir), .load(load), .load_val(load_val),
        .cnt_bin(bin0), .cnt_gray(gray0), .at_max(amax0), .at_min(amin0), .wrap(wrap0), .chk_err(cerr0)
    );

    gray_counter_ud #(.WIDTH(8), .SATURATE(1), .RST_VAL(8'hA5)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .dir(dir), .load(load), .load_val(load_val),
        .cnt_bin(bin1), .cnt_gray(gray1), .at_max(amax1), .at_min(amin1), .wrap(wrap1), .chk_err(cerr1)
    );

    // Model: the counting rules stated as plain integer arithmetic on 0..255
    function automatic int nextVal(int cur, bit sat, int rv, bit r, bit ld, int lv, bit en, bit d);
        if (r) return rv;
        if (ld) return lv;
        if (!en) return cur;
        if (d) begin
            if (cur == 255) return sat ? 255 : 0;
            return cur + 1;
        end
        if (cur == 0) return sat ? 0 : 255;
        return cur - 1;
    endfunction

    function automatic bit nextWrap(int cur, bit sat, bit r, bit ld, bit en, bit d);
        return !r && !ld && en && !sat && ((d && cur == 255) || (!d && cur == 0));
    endfunction

    function automatic int toGray(int v);
        return v ^ (v >> 1);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mv[k]     <= nextVal(mv[k], SATV[k], RSTV[k], rst, load, int'(load_val), enable, dir);
            mw[k]     <= nextWrap(mv[k], SATV[k], rst, load, enable, dir);
            mmoved[k] <= !rst && !load && enable &&
                         (nextVal(mv[k], SATV[k], RSTV[k], 1'b0, 1'b0, 0, 1'b1, dir) != mv[k]);
            mprev[k]  <= toGray(mv[k]);
        end
        mvalid <= mvalid | rst;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkDut(input int k, input logic [7:0] b, input logic [7:0] g,
                            input logic amx, input logic amn, input logic w, input logic ce);
        checkOutput($sformatf("d%0d.cnt_bin", k), 32'(b), 32'(mv[k]));
        checkOutput($sformatf("d%0d.cnt_gray", k), 32'(g), 32'(toGray(mv[k])));
        checkOutput($sformatf("d%0d.at_max", k), 32'(amx), 32'(mv[k] == 255));
        checkOutput($sformatf("d%0d.at_min", k), 32'(amn), 32'(mv[k] == 0));
        checkOutput($sformatf("d%0d.wrap", k), 32'(w), 32'(mw[k]));
        checkOutput($sformatf("d%0d.chk_err", k), 32'(ce), 32'(0));
        if (mmoved[k]) begin
            checkOutput($sformatf("d%0d.gray_one_bit", k), 32'($countones(g ^ 8'(mprev[k]))), 32'(1));
        end
    endtask

    always @(negedge clk) begin
        if (mvalid && !pauseCmp) begin
            checkDut(0, bin0, gray0, amax0, amin0, wrap0, cerr0);
            checkDut(1, bin1, gray1, amax1, amin1, wrap1, cerr1);
        end
    end

    task automatic applyStimulus(input bit r, input bit ld, input logic [7:0] lv, input bit en, input bit d);
        rst      = r;
        load     = ld;
        load_val = lv;
        enable   = en;
        dir      = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        bad++;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wrapCnt;
        logic [7:0] grayExp1[4];
        logic [7:0] binExp2[6];
        logic [7:0] binExp5[4];
        grayExp1 = '{8'h01, 8'h03, 8'h02, 8'h06};
        binExp2  = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'hFF};
        binExp5  = '{8'h81, 8'h80, 8'h81, 8'h80};

        applyStimulus(1, 0, 8'h00, 0, 0);
        applyStimulus(1, 0, 8'h00, 0, 0);
        checkOutput("rst bin0", 32'(bin0), 32'h00);
        checkOutput("rst gray0", 32'(gray0), 32'h00);
        checkOutput("rst at_min0", 32'(amin0), 32'd1);
        checkOutput("rst at_max0", 32'(amax0), 32'd0);
        checkOutput("rst wrap0", 32'(wrap0), 32'd0);
        checkOutput("rst chk_err0", 32'(cerr0), 32'd0);
        checkOutput("rst bin1", 32'(bin1), 32'hA5);
        checkOutput("rst gray1", 32'(gray1), 32'hF7);

        // Full lap upwards: exactly one wrap pulse, landing back on zero
        wrapCnt = 0;
        for (int i = 1; i <= 256; i++) begin
            applyStimulus(0, 0, 8'h00, 1, 1);
            if (wrap0 === 1'b1) wrapCnt++;
            if (i <= 4) checkOutput($sformatf("t1 gray step%0d", i), 32'(gray0), 32'(grayExp1[i-1]));
        end
        checkOutput("t1 wrap count", 32'(wrapCnt), 32'd1);
        checkOutput("t1 final bin", 32'(bin0), 32'h00);
        checkOutput("t1 final wrap", 32'(wrap0), 32'd1);
        checkOutput("t1 sat held", 32'(bin1), 32'hFF);

        applyStimulus(0, 1, 8'h05, 0, 0);
        checkOutput("t2 load", 32'(bin0), 32'h05);
        checkOutput("t2 load wrap", 32'(wrap0), 32'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 8'h00, 1, 0);
            checkOutput($sformatf("t2 bin%0d", i), 32'(bin0), 32'(binExp2[i]));
            checkOutput($sformatf("t2 wrap%0d", i), 32'(wrap0), 32'(i == 5));
            checkOutput($sformatf("t2 at_min%0d", i), 32'(amin0), 32'(i == 4));
        end

        applyStimulus(0, 1, 8'hFE, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 8'h00, 1, 1);
            checkOutput($sformatf("t3 sat bin%0d", i), 32'(bin1), 32'hFF);
            checkOutput($sformatf("t3 sat at_max%0d", i), 32'(amax1), 32'd1);
            checkOutput($sformatf("t3 sat wrap%0d", i), 32'(wrap1), 32'd0);
        end
        applyStimulus(0, 1, 8'h01, 0, 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 8'h00, 1, 0);
            checkOutput($sformatf("t3 sat down%0d", i), 32'(bin1), 32'h00);
        end

        applyStimulus(0, 1, 8'h40, 1, 1);
        checkOutput("t4 load beats enable", 32'(bin0), 32'h40);
        checkOutput("t4 load beats enable sat", 32'(bin1), 32'h40);
        applyStimulus(1, 1, 8'h77, 1, 1);
        checkOutput("t4 rst beats load", 32'(bin0), 32'h00);
        checkOutput("t4 rst beats load sat", 32'(bin1), 32'hA5);

        applyStimulus(0, 1, 8'h80, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 8'h00, 1, (i % 2 == 0));
            checkOutput($sformatf("t5 bin%0d", i), 32'(bin0), 32'(binExp5[i]));
            checkOutput($sformatf("t5 chk_err%0d", i), 32'(cerr0), 32'd0);
        end

`ifdef GRAY_CNT_CHK_EN
        begin
            logic [7:0] grayBefore;
            logic [7:0] forced;
            applyStimulus(0, 1, 8'h10, 0, 0);
            pauseCmp   = 1'b1;
            grayBefore = gray0;
            applyStimulus(0, 0, 8'h00, 1, 1);
            forced = grayBefore ^ 8'h03;
            force dut.gray_q = forced;
            applyStimulus(0, 0, 8'h00, 0, 0);
            checkOutput("t6 chk_err set", 32'(cerr0), 32'd1);
            release dut.gray_q;
            applyStimulus(0, 0, 8'h00, 0, 0);
            checkOutput("t6 chk_err sticky", 32'(cerr0), 32'd1);
            applyStimulus(1, 0, 8'h00, 0, 0);
            checkOutput("t6 chk_err cleared", 32'(cerr0), 32'd0);
            pauseCmp = 1'b0;
        end
`endif

        applyStimulus(0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
